// File: rtl/symbol_x_checker_if.sv
// Plot-bus bundle between a symbol drawer (master) and the X checker (slave).
// Carries start/origin, pixel plots, done strobe and the checker's result outputs.
interface symbol_x_checker_if;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       done;
  logic       busy;
  logic       valid;
  logic       match;
  logic       oob;
  logic [8:0] pix_count;

  modport master (
    output start, x0, y0, plot, x, y, colour, done,
    input  busy, valid, match, oob, pix_count
  );

  modport slave (
    input  start, x0, y0, plot, x, y, colour, done,
    output busy, valid, match, oob, pix_count
  );
endinterface

// File: rtl/symbol_x_checker.sv
// Captures plotted pixels of a 16x16 tile and checks them against an X pattern.
// Ports: clk, reset_n (async low), bus (slave: start/x0/y0/plot/x/y/colour/done in;
// busy/valid/match/oob/pix_count out). Optional colour checking: COLOUR_CHECK_EN.
module symbol_x_checker (
  input  logic clk,
  input  logic reset_n,
  symbol_x_checker_if.slave bus
);

  localparam logic [2:0] EXP_COLOUR = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    CHECK,
    REPORT
  } state_e;

  state_e            state_q, state_d;
  logic [15:0][15:0] bmp_q, bmp_d;
  logic [7:0]        x0_q, x0_d;
  logic [6:0]        y0_q, y0_d;
  logic [3:0]        row_q, row_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              oob_q, oob_d;
  logic              err_q, err_d;
  logic              cerr_q, cerr_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              match_q, match_d;

  logic [7:0]  dx;
  logic [6:0]  dy;
  logic        in_tile;
  logic [15:0] exp_row;
  logic [8:0]  cnt_inc;

  // Offsets wrap naturally in their own width, so a tile may
  // straddle the screen edge.
  assign dx      = bus.x - x0_q;
  assign dy      = bus.y - y0_q;
  assign in_tile = (dx[7:4] == 4'd0) && (dy[6:4] == 3'd0);
  assign exp_row = (16'd1 << row_q) | (16'd1 << (4'd15 - row_q));
  assign cnt_inc = (cnt_q == 9'd511) ? cnt_q : cnt_q + 9'd1;

  always_comb begin
    state_d = state_q;
    bmp_d   = bmp_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    oob_d   = oob_q;
    err_d   = err_q;
    cerr_d  = cerr_q;
    valid_d = 1'b0;
    match_d = match_q;

    if (bus.start) begin
      state_d = CAPTURE;
      bmp_d   = '0;
      x0_d    = bus.x0;
      y0_d    = bus.y0;
      row_d   = 4'd0;
      cnt_d   = 9'd0;
      oob_d   = 1'b0;
      err_d   = 1'b0;
      cerr_d  = 1'b0;
      match_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        CAPTURE: begin
          if (bus.plot) begin
            if (in_tile) begin
`ifdef COLOUR_CHECK_EN
              if (bus.colour == 3'b000) begin
                bmp_d[dy[3:0]][dx[3:0]] = 1'b0;
              end else begin
                bmp_d[dy[3:0]][dx[3:0]] = 1'b1;
                cnt_d = cnt_inc;
                if (bus.colour != EXP_COLOUR) cerr_d = 1'b1;
              end
`else
              bmp_d[dy[3:0]][dx[3:0]] = 1'b1;
              cnt_d = cnt_inc;
`endif
            end else begin
              oob_d = 1'b1;
            end
          end
          if (bus.done) begin
            state_d = CHECK;
            row_d   = 4'd0;
          end
        end
        CHECK: begin
          if (bmp_q[row_q] != exp_row) err_d = 1'b1;
          row_d = row_q + 4'd1;
          if (row_q == 4'd15) state_d = REPORT;
        end
        REPORT: begin
          valid_d = 1'b1;
          match_d = !err_q && !oob_q && !cerr_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Busy covers REPORT too so it drops together with the valid pulse.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bmp_q   <= '0;
      x0_q    <= 8'd0;
      y0_q    <= 7'd0;
      row_q   <= 4'd0;
      cnt_q   <= 9'd0;
      oob_q   <= 1'b0;
      err_q   <= 1'b0;
      cerr_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bmp_q   <= bmp_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      oob_q   <= oob_d;
      err_q   <= err_d;
      cerr_q  <= cerr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      match_q <= match_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.match     = match_q;
  assign bus.oob       = oob_q;
  assign bus.pix_count = cnt_q;

endmodule

// File: tb/tb_symbol_x_checker.sv
// Bench for symbol_x_checker: scenario table, corner sequences and
// randomized tiles checked against a pixel-level model.
module tb_symbol_x_checker;

  localparam logic [2:0] EXP = 3'b101;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    string      name;
    logic [7:0] ox;
    logic [6:0] oy;
    int         kind;
    bit         dlast;
    bit         m;
    int         pix;
    bit         oob;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  symbol_x_checker_if bus();

  symbol_x_checker dut (
    .clk    (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  pix_t plot_q[$];
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic push(input int x, input int y, input logic [2:0] c);
    pix_t p;
    p.x = 8'(x);
    p.y = 7'(y);
    p.c = c;
    plot_q.push_back(p);
  endtask

  // kinds: 0 clean X, 1 missing (+7,+7), 2 clean + out-of-tile,
  // 4 empty, 5 one pixel in colour 010, 6 clean + erase of origin
  task automatic build(input int kind, input logic [7:0] ox,
                       input logic [6:0] oy);
    plot_q.delete();
    if (kind != 4) begin
      for (int i = 0; i < 16; i++) begin
        if (!(kind == 1 && i == 7)) push(ox + i, oy + i, EXP);
        push(ox + 15 - i, oy + i, EXP);
      end
    end
    if (kind == 2) push(ox + 16, oy, EXP);
    if (kind == 5) plot_q[3].c = 3'b010;
    if (kind == 6) push(ox, oy, 3'b000);
  endtask

  function automatic void model(input logic [7:0] ox, input logic [6:0] oy,
                                output bit m, output int cnt, output bit oob);
    bit bm[16][16];
    bit cerr;
    cnt = 0;
    oob = 0;
    cerr = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) bm[r][c] = 0;
    foreach (plot_q[i]) begin
      int dx;
      int dy;
      dx = (int'(plot_q[i].x) - int'(ox) + 256) % 256;
      dy = (int'(plot_q[i].y) - int'(oy) + 128) % 128;
      if (dx < 16 && dy < 16) begin
`ifdef COLOUR_CHECK_EN
        if (plot_q[i].c == 3'b000) begin
          bm[dy][dx] = 0;
        end else begin
          bm[dy][dx] = 1;
          if (cnt < 511) cnt++;
          if (plot_q[i].c != EXP) cerr = 1;
        end
`else
        bm[dy][dx] = 1;
        if (cnt < 511) cnt++;
`endif
      end else begin
        oob = 1;
      end
    end
    m = !oob && !cerr;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (bm[r][c] != (r == c || r + c == 15)) m = 0;
  endfunction

  task automatic idle_in();
    bus.start = 0;
    bus.x0 = 0;
    bus.y0 = 0;
    bus.plot = 0;
    bus.x = 0;
    bus.y = 0;
    bus.colour = 0;
    bus.done = 0;
  endtask

  task automatic do_start(input logic [7:0] ox, input logic [6:0] oy,
                          input bit pl, input logic [7:0] px,
                          input logic [6:0] py);
    @(negedge clk);
    bus.start = 1;
    bus.x0 = ox;
    bus.y0 = oy;
    bus.plot = pl;
    bus.x = px;
    bus.y = py;
    bus.colour = EXP;
    bus.done = 0;
  endtask

  task automatic do_plots(input bit dlast, input bit gaps);
    int n;
    n = plot_q.size();
    foreach (plot_q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.start = 0;
        bus.plot = 0;
        bus.done = 0;
      end
      @(negedge clk);
      bus.start = 0;
      bus.plot = 1;
      bus.x = plot_q[i].x;
      bus.y = plot_q[i].y;
      bus.colour = plot_q[i].c;
      bus.done = dlast && (i == n - 1);
    end
    if (!dlast || n == 0) begin
      @(negedge clk);
      bus.start = 0;
      bus.plot = 0;
      bus.done = 1;
    end
    @(negedge clk);
    bus.start = 0;
    bus.plot = 0;
    bus.done = 0;
  endtask

  task automatic wait_result(input string nm, input bit m, input int pix,
                             input bit oob);
    int lat;
    int b16;
    lat = 0;
    b16 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 16) b16 = int'(bus.busy);
      if (bus.valid) begin
        lat = k;
        break;
      end
    end
    chk({nm, " latency"}, lat, 17);
    if (lat != 0) begin
      chk({nm, " busy late"}, b16, 1);
      chk({nm, " match"}, int'(bus.match), int'(m));
      chk({nm, " pix"}, int'(bus.pix_count), pix);
      chk({nm, " oob"}, int'(bus.oob), int'(oob));
      chk({nm, " busy end"}, int'(bus.busy), 0);
      @(posedge clk);
      #1;
      chk({nm, " valid pulse"}, int'(bus.valid), 0);
      chk({nm, " match held"}, int'(bus.match), int'(m));
    end
  endtask

  initial begin
    vec_t       v;
    bit         em;
    int         ep;
    bit         eo;
    logic [7:0] ox;
    logic [6:0] oy;

    idle_in();
    #12;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset valid", int'(bus.valid), 0);
    chk("reset match", int'(bus.match), 0);
    chk("reset oob", int'(bus.oob), 0);
    chk("reset pix", int'(bus.pix_count), 0);
    @(negedge clk);
    rst_n = 1;

    tbl.push_back('{"clean", 8'd40, 7'd30, 0, 0, 1, 32, 0});
    tbl.push_back('{"clean_dlast", 8'd40, 7'd30, 0, 1, 1, 32, 0});
    tbl.push_back('{"missing", 8'd40, 7'd30, 1, 0, 0, 31, 0});
    tbl.push_back('{"oob", 8'd40, 7'd30, 2, 0, 0, 32, 1});
    tbl.push_back('{"wrap_x", 8'd250, 7'd30, 0, 0, 1, 32, 0});
    tbl.push_back('{"wrap_y", 8'd100, 7'd120, 0, 1, 1, 32, 0});
    tbl.push_back('{"empty", 8'd0, 7'd0, 4, 0, 0, 0, 0});
`ifdef COLOUR_CHECK_EN
    tbl.push_back('{"bad_colour", 8'd40, 7'd30, 5, 0, 0, 32, 0});
    tbl.push_back('{"erase", 8'd40, 7'd30, 6, 0, 0, 32, 0});
`endif

    foreach (tbl[t]) begin
      v = tbl[t];
      build(v.kind, v.ox, v.oy);
      do_start(v.ox, v.oy, 0, 0, 0);
      do_plots(v.dlast, 0);
      wait_result(v.name, v.m, v.pix, v.oob);
    end

    // IDLE ignores plot and done; results stay held
    build(0, 40, 30);
    do_start(40, 30, 0, 0, 0);
    do_plots(0, 0);
    wait_result("pre_idle", 1, 32, 0);
    @(negedge clk);
    bus.plot = 1;
    bus.x = 40;
    bus.y = 30;
    bus.done = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("idle valid", int'(bus.valid), 0);
      chk("idle busy", int'(bus.busy), 0);
      chk("idle pix", int'(bus.pix_count), 32);
    end
    @(negedge clk);
    idle_in();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk("idle no valid", int'(bus.valid), 0);
    end
    chk("idle match held", int'(bus.match), 1);

    // Abort 5 cycles into CHECK; the restart cycle carries a plot
    // that must be dropped, and the old X must be gone.
    build(0, 40, 30);
    do_start(40, 30, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("start busy", int'(bus.busy), 1);
    do_plots(0, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk("abort chk valid", int'(bus.valid), 0);
      chk("abort chk busy", int'(bus.busy), 1);
    end
    do_start(40, 30, 1, 47, 37);
    @(posedge clk);
    #1;
    chk("abort busy", int'(bus.busy), 1);
    chk("abort valid", int'(bus.valid), 0);
    chk("abort pix", int'(bus.pix_count), 0);
    chk("abort match", int'(bus.match), 0);
    build(1, 40, 30);
    do_plots(0, 0);
    wait_result("after_abort", 0, 31, 0);
    build(0, 40, 30);
    do_start(40, 30, 0, 0, 0);
    do_plots(0, 0);
    wait_result("second_clean", 1, 32, 0);

    // pix_count saturation
    plot_q.delete();
    for (int i = 0; i < 520; i++) push(10, 10, EXP);
    do_start(10, 10, 0, 0, 0);
    do_plots(0, 0);
    wait_result("saturate", 0, 511, 0);

    // randomized tiles against the model
    for (int it = 0; it < 25; it++) begin
      ox = 8'($urandom);
      oy = 7'($urandom);
      plot_q.delete();
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 15) != 0) push(ox + i, oy + i, EXP);
        if ($urandom_range(0, 15) != 0) push(ox + 15 - i, oy + i, EXP);
      end
      for (int e = 0; e < int'($urandom_range(0, 2)); e++)
        push(ox + $urandom_range(0, 19), oy + $urandom_range(0, 19), EXP);
      foreach (plot_q[i]) begin
        if ($urandom_range(0, 19) == 0) plot_q[i].c = 3'($urandom);
        if ($urandom_range(0, 9) < 3) plot_q.shuffle();
      end
      model(ox, oy, em, ep, eo);
      do_start(ox, oy, 0, 0, 0);
      do_plots(1'($urandom), 1);
      wait_result($sformatf("rand%0d", it), em, ep, eo);
    end

    // asynchronous reset mid-capture
    build(0, 40, 30);
    do_start(40, 30, 0, 0, 0);
    @(negedge clk);
    bus.start = 0;
    bus.plot = 1;
    bus.x = 40;
    bus.y = 30;
    @(posedge clk);
    #2;
    chk("pre reset pix", int'(bus.pix_count), 1);
    rst_n = 0;
    #1;
    chk("async busy", int'(bus.busy), 0);
    chk("async pix", int'(bus.pix_count), 0);
    chk("async match", int'(bus.match), 0);
    idle_in();
    @(negedge clk);
    rst_n = 1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/symbol_x_checker.md
# symbol_x_checker

Receiver for the pixel-plot stream produced by the symbol drawers. It captures every plotted pixel of one 16x16 symbol tile into an internal bitmap, relative to a latched origin. On an end-of-symbol strobe it checks the bitmap row by row against the X pattern, meaning both diagonals of the tile. It sits on the plot bus between the drawer and the VGA adapter and self-checks drawing during play and bring-up.

## Interface
- EXP_COLOUR, 3'b101, colour the drawer uses for X pixels.
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle strobe: clear the bitmap, latch the origin, begin capture.
- x0  in  8  tile origin x, latched on start.
- y0  in  7  tile origin y, latched on start.
- plot  in  1  pixel-valid strobe, sampled every cycle.
- x  in  8  pixel x.
- y  in  7  pixel y.
- colour  in  3  pixel colour.
- done  in  1  end-of-symbol strobe; the drawer's next/carryout.
- busy  out  1  high in CAPTURE and CHECK.
- valid  out  1  one-cycle pulse in REPORT.
- match  out  1  result; held until the next start.
- oob  out  1  sticky: a plot landed outside the tile.
- pix_count  out  9  count of accepted plots, saturates at 511.

## Operation
- States: IDLE, CAPTURE, CHECK, REPORT.
- IDLE:
  - plot and done are ignored.
  - start goes to CAPTURE.
- CAPTURE:
  - On start: bitmap is all zeros, pix_count=0, oob=0, match=0, origin is latched.
  - For each plot, dx=(x-x0) mod 256 and dy=(y-y0) mod 128.
  - In-tile when dx<16 and dy<16: set bit[dy][dx] and increment pix_count (saturating).
  - Otherwise set oob and leave the bitmap unchanged.
  - done goes to CHECK. A plot in the same cycle as done is captured first.
- CHECK:
  - A 4-bit row index r runs 0..15, one row per cycle.
  - The expected row has exactly bits r and 15-r set.
  - Any mismatch sets an internal sticky error.
  - After r=15, go to REPORT.
- REPORT:
  - valid=1 for one cycle.
  - match = no mismatch AND oob=0 AND (colour error =0 when configured).
  - Then go to IDLE.
- start in any state (CAPTURE, CHECK, REPORT) aborts and restarts capture. match goes to 0 and valid is not pulsed.
- start and plot in the same cycle: start wins and the plot is dropped.
- plot in CHECK or REPORT is ignored.
- done in IDLE, CHECK or REPORT is ignored.
- The bitmap, oob and pix_count are held in IDLE for debug until the next start.

## Timing
- Reset (async, immediate): state=IDLE, bitmap=0, busy=0, valid=0, match=0, oob=0, pix_count=0.
- All outputs are registered.
- start at edge N: busy=1 from N+1.
- A plot sampled at edge N is visible in the bitmap and pix_count after N.
- done at edge D: CHECK covers D+1..D+16, valid and match are updated at D+17, busy=0 from D+17.
- The drawer's 16-cycle X stroke followed by done gives a result 17 cycles after done.

## Configuration
- COLOUR_CHECK_EN defined:
  - In CAPTURE, colour 3'b000 clears bit[dy][dx] (erase) and does not increment pix_count.
  - colour==EXP_COLOUR sets the bit.
  - Any other colour sets the bit and sets a sticky colour error, which forces match=0.
  - The colour error is cleared on start and on reset.
- COLOUR_CHECK_EN undefined: colour is ignored and every in-tile plot sets its bit.

## Test plan
- **Clean X:** x0=40,y0=30, start, then 32 plots at (40+i,30+i) and (55-i,30+i) for i=0..15, then done. Required: valid at done+17, match=1, pix_count=32, oob=0.
- **Missing pixel:** as clean X but omit (47,37). Required: match=0, pix_count=31.
- **Out of tile:** clean X plus a plot at (56,30). Required: oob=1, match=0, pix_count=32.
- **Wrap-around:** x0=250, plot at x=3 (dx=9), all other pixels correct. Required: accepted in-tile; match follows the pattern.
- **Abort:** start again 5 cycles into CHECK. Required: no valid pulse, busy stays 1, bitmap=0; a second clean X then gives match=1.
- **Colour (COLOUR_CHECK_EN):** clean X with one pixel in colour 3'b010. Required: match=0. Clean X plus a colour-000 erase of (40,30). Required: match=0, pix_count=32.
